// File: rtl/cakegame_ram_arbiter_pkg.sv
// Cake game RAM arbiter shared types.
// Requester IDs, FSM state codes and owner helper.
package cakegame_pkg;

  localparam logic [1:0] RQ_NONE  = 2'd0;
  localparam logic [1:0] RQ_WRITE = 2'd1;
  localparam logic [1:0] RQ_GAME  = 2'd2;
  localparam logic [1:0] RQ_SCAN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic logic [1:0] gnt_owner(
    input logic w,
    input logic g,
    input logic s
  );
    if (w) return RQ_WRITE;
    if (g) return RQ_GAME;
    if (s) return RQ_SCAN;
    return RQ_NONE;
  endfunction

endpackage

// File: rtl/cakegame_ram_arbiter_if.sv
// Requester-side bus of the cake game RAM arbiter.
// master = controller/datapath, slave = arbiter.
interface cakegame_ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);

  logic              clear_req;
  logic              clear_busy;
  logic              w_req;
  logic              w_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              g_req;
  logic              g_gnt;
  logic [ADDR_W-1:0] g_addr;
  logic              s_req;
  logic              s_gnt;
  logic [ADDR_W-1:0] s_addr;
  logic              rd_valid;
  logic [1:0]        rd_owner;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output clear_req, w_req, w_addr, w_data,
    output g_req, g_addr, s_req, s_addr,
    input  clear_busy, w_gnt, g_gnt, s_gnt,
    input  rd_valid, rd_owner, rd_data
  );

  modport slave (
    input  clear_req, w_req, w_addr, w_data,
    input  g_req, g_addr, s_req, s_addr,
    output clear_busy, w_gnt, g_gnt, s_gnt,
    output rd_valid, rd_owner, rd_data
  );

endinterface

// File: rtl/cakegame_ram_clear_seq.sv
// Clear sweep sequencer: rising edge of clear_req
// starts one pass writing every RAM address once.
module cakegame_ram_clear_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              start,
  output logic              busy,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic clr_q;

  assign start = clear_req & ~clr_q & ~busy;
  assign last  = busy & (addr == '1);

  // Edge flop plus sweep address counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_q <= 1'b0;
      busy  <= 1'b0;
      addr  <= '0;
    end else begin
      clr_q <= clear_req;
      if (start) begin
        busy <= 1'b1;
        addr <= '0;
      end else if (busy) begin
        addr <= addr + 1'b1;
        if (last) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cakegame_ram_arbiter.sv
// Single-port sequence RAM arbiter for the cake game:
// writer > game read > scanner, with scanner anti-starvation.
module cakegame_ram_arbiter
  import cakegame_pkg::*;
#(
  parameter int              ADDR_W     = 4,
  parameter int              DATA_W     = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int              STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  cakegame_ram_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_t            st;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic [SW-1:0]     starve;
  logic              promote;
  logic              arb_en;
  logic              w_gnt;
  logic              g_gnt;
  logic              s_gnt;
  logic              rd_valid_q;
  logic [1:0]        rd_owner_q;

  cakegame_ram_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clock    (clock),
    .reset    (reset),
    .clear_req(bus.clear_req),
    .start    (clr_start),
    .busy     (clr_busy),
    .last     (clr_last),
    .addr     (clr_addr)
  );

  // Grants are held off in reset and while sweeping
  assign arb_en  = reset && (st != ST_CLEAR);
  assign promote = (starve == SMAX);

  // Fixed priority with scanner promotion
  always_comb begin
    w_gnt = 1'b0;
    g_gnt = 1'b0;
    s_gnt = 1'b0;
    if (arb_en) begin
      priority case (1'b1)
        bus.w_req:             w_gnt = 1'b1;
        promote && bus.s_req:  s_gnt = 1'b1;
        bus.g_req:             g_gnt = 1'b1;
        bus.s_req:             s_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  // RAM port driven by the sweep or the granted access
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      clr_busy: begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = CLEAR_VAL;
      end
      w_gnt: begin
        ram_we    = 1'b1;
        ram_addr  = bus.w_addr;
        ram_wdata = bus.w_data;
      end
      g_gnt: ram_addr = bus.g_addr;
      s_gnt: ram_addr = bus.s_addr;
      default: ;
    endcase
  end

  // Scanner starvation counter, saturating
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (!bus.s_req || s_gnt) begin
      starve <= '0;
    end else if (starve != SMAX) begin
      starve <= starve + 1'b1;
    end
  end

  // Read return tag, one cycle after the grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= RQ_NONE;
    end else begin
      rd_valid_q <= g_gnt | s_gnt;
      rd_owner_q <= (g_gnt | s_gnt)
                  ? gnt_owner(w_gnt, g_gnt, s_gnt)
                  : RQ_NONE;
    end
  end

  // Arbiter state: idle, served last cycle, or sweeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_CLEAR: if (clr_last) st <= ST_IDLE;
        default: begin
          if (clr_start)
            st <= ST_CLEAR;
          else if (w_gnt | g_gnt | s_gnt)
            st <= ST_SERVE;
          else
            st <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.w_gnt      = w_gnt;
  assign bus.g_gnt      = g_gnt;
  assign bus.s_gnt      = s_gnt;
  assign bus.clear_busy = clr_busy;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_owner   = rd_owner_q;
  assign bus.rd_data    = rd_valid_q ? ram_rdata : '0;
  assign state          = st;

endmodule
